// File: rtl/tlb_pkg.sv
// Shared definitions for the joint TLB controller: entry layout, op codes, FSM states.
package tlb_pkg;

    localparam int N_ENTRIES = 16;
    localparam int ENTRY_W   = 71;
    localparam int IDX_W     = 4;
    localparam int VPN2_W    = 19;
    localparam int LO_W      = 26;

    // Entry field bit positions
    localparam int VPN2_HI = 70;
    localparam int VPN2_LO = 52;
    localparam int PFN1_HI = 51;
    localparam int PFN1_LO = 28;
    localparam int D1      = 27;
    localparam int V1      = 26;
    localparam int PFN0_HI = 25;
    localparam int PFN0_LO = 2;
    localparam int D0      = 1;
    localparam int V0      = 0;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_t;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Assemble an entry from CP0 EntryHi/EntryLo1/EntryLo0 images
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [VPN2_W-1:0] vpn2,
        input logic [LO_W-1:0]   lo1,
        input logic [LO_W-1:0]   lo0
    );
        logic [ENTRY_W-1:0] e;
        e                   = '0;
        e[VPN2_HI:VPN2_LO]  = vpn2;
        e[PFN1_HI:PFN1_LO]  = lo1[LO_W-1:2];
        e[D1]               = lo1[1];
        e[V1]               = lo1[0];
        e[PFN0_HI:PFN0_LO]  = lo0[LO_W-1:2];
        e[D0]               = lo0[1];
        e[V0]               = lo0[0];
        return e;
    endfunction

endpackage

// File: rtl/tlb_random_counter.sv
// CP0 Random register: free-running down-counter bounded below by Wired.
module tlb_random_counter
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] wired_in,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random_out
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(N_ENTRIES - 1);

    // Decrement every cycle, wrapping to the top once the wired floor is reached
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            random_out <= RAND_TOP;
        end else if (wired_we) begin
            random_out <= RAND_TOP;
        end else if (random_out <= wired_in) begin
            random_out <= RAND_TOP;
        end else begin
            random_out <= random_out - 1'b1;
        end
    end

endmodule

// File: rtl/tlb_ctrl.sv
// Joint TLB array owner executing TLBR/TLBWI/TLBWR/TLBP for CP0.
module tlb_ctrl
    import tlb_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                op_valid,
    input  logic [1:0]                          op,
    output logic                                op_ready,
    output logic                                op_done,
    input  logic [IDX_W-1:0]                    index_in,
    input  logic [VPN2_W-1:0]                   entryhi_in,
    input  logic [LO_W-1:0]                     entrylo0_in,
    input  logic [LO_W-1:0]                     entrylo1_in,
    input  logic [IDX_W-1:0]                    wired_in,
    input  logic                                wired_we,
    output logic [N_ENTRIES-1:0][ENTRY_W-1:0]   tlb_entries,
    output logic [IDX_W-1:0]                    random_out,
    output logic [VPN2_W-1:0]                   rd_entryhi,
    output logic [LO_W-1:0]                     rd_entrylo0,
    output logic [LO_W-1:0]                     rd_entrylo1,
    output logic [IDX_W-1:0]                    probe_index,
    output logic                                probe_miss
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    logic [N_ENTRIES-1:0][ENTRY_W-1:0] entries;
    logic [1:0]                        state;
    logic [IDX_W-1:0]                  scan_idx;
    logic [VPN2_W-1:0]                 probe_vpn;
    tlb_op_t                           op_code;
    logic                              accept;
    logic                              wr_en;
    logic [IDX_W-1:0]                  wr_idx;
    logic [ENTRY_W-1:0]                wr_data;
    logic [ENTRY_W-1:0]                read_entry;
    logic                              probe_hit;

    tlb_random_counter u_random (
        .clk        (clk),
        .rst_n      (rst_n),
        .wired_in   (wired_in),
        .wired_we   (wired_we),
        .random_out (random_out)
    );

    assign op_code     = tlb_op_t'(op);
    assign op_ready    = (state == ST_IDLE);
    assign op_done     = (state == ST_DONE);
    assign tlb_entries = entries;

    // Decode the accepted request into a write port and evaluate the current probe compare
    always_comb begin
        accept     = (state == ST_IDLE) && op_valid;
        wr_en      = 1'b0;
        wr_idx     = index_in;
        wr_data    = pack_entry(entryhi_in, entrylo1_in, entrylo0_in);
        read_entry = entries[index_in];
        probe_hit  = (entries[scan_idx][VPN2_HI:VPN2_LO] == probe_vpn);
        if (accept && (op_code == OP_TLBWI)) begin
            wr_en = 1'b1;
        end
        if (accept && (op_code == OP_TLBWR)) begin
            wr_en  = 1'b1;
            wr_idx = random_out;
        end
    end

    // Entry array storage, cleared by reset and written by TLBWI/TLBWR at accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

    // Sequencing FSM with TLBR read-out and the linear TLBP scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            scan_idx    <= '0;
            probe_vpn   <= '0;
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
            probe_index <= '0;
            probe_miss  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_TLBR: begin
                                rd_entryhi  <= read_entry[VPN2_HI:VPN2_LO];
                                rd_entrylo1 <= {read_entry[PFN1_HI:PFN1_LO], read_entry[D1], read_entry[V1]};
                                rd_entrylo0 <= {read_entry[PFN0_HI:PFN0_LO], read_entry[D0], read_entry[V0]};
                                state       <= ST_DONE;
                            end
                            OP_TLBP: begin
                                scan_idx  <= '0;
                                probe_vpn <= entryhi_in;
                                state     <= ST_PROBE;
                            end
                            default: begin
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_PROBE: begin
                    if (probe_hit) begin
                        probe_index <= scan_idx;
                        probe_miss  <= 1'b0;
                        state       <= ST_DONE;
                    end else if (scan_idx == LAST_IDX) begin
                        probe_miss <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl against a behavioural TLB model.
module tb_tlb_ctrl;
    import tlb_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              op_valid;
    logic [1:0]                        op;
    logic                              op_ready;
    logic                              op_done;
    logic [3:0]                        index_in;
    logic [18:0]                       entryhi_in;
    logic [25:0]                       entrylo0_in;
    logic [25:0]                       entrylo1_in;
    logic [3:0]                        wired_in;
    logic                              wired_we;
    logic [15:0][70:0]                 tlb_entries;
    logic [3:0]                        random_out;
    logic [18:0]                       rd_entryhi;
    logic [25:0]                       rd_entrylo0;
    logic [25:0]                       rd_entrylo1;
    logic [3:0]                        probe_index;
    logic                              probe_miss;

    tlb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op          (op),
        .op_ready    (op_ready),
        .op_done     (op_done),
        .index_in    (index_in),
        .entryhi_in  (entryhi_in),
        .entrylo0_in (entrylo0_in),
        .entrylo1_in (entrylo1_in),
        .wired_in    (wired_in),
        .wired_we    (wired_we),
        .tlb_entries (tlb_entries),
        .random_out  (random_out),
        .rd_entryhi  (rd_entryhi),
        .rd_entrylo0 (rd_entrylo0),
        .rd_entrylo1 (rd_entrylo1),
        .probe_index (probe_index),
        .probe_miss  (probe_miss)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [70:0] m_mem [16];
    logic [70:0] m_rd;
    logic [3:0]  m_probe_index;
    logic        m_probe_miss;
    int          m_rand = 15;

    // Random register rule: reset/wired write -> 15, at or below wired -> 15, else count down
    always @(posedge clk) begin
        if (rst_n !== 1'b1 || wired_we === 1'b1) m_rand = 15;
        else if (m_rand <= int'(wired_in))       m_rand = 15;
        else                                      m_rand = m_rand - 1;
    end

    logic [1:0]  r_op;
    logic [3:0]  r_idx;
    logic [18:0] r_hi;
    logic [25:0] r_lo0;
    logic [25:0] r_lo1;
    int          seq [6] = '{15, 14, 13, 12, 15, 14};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkEntries(input string tag);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("%s_entry%0d", tag, i), tlb_entries[i], m_mem[i]);
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, "_rd_hi"},  rd_entryhi,  m_rd[70:52]);
        checkOutput({tag, "_rd_lo1"}, rd_entrylo1, m_rd[51:26]);
        checkOutput({tag, "_rd_lo0"}, rd_entrylo0, m_rd[25:0]);
        checkOutput({tag, "_pidx"},   probe_index, m_probe_index);
        checkOutput({tag, "_pmiss"},  probe_miss,  m_probe_miss);
        checkOutput({tag, "_random"}, random_out,  m_rand);
    endtask

    task automatic resetModel();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_rd          = '0;
        m_probe_index = '0;
        m_probe_miss  = 1'b0;
    endtask

    // Issue one op, update the model, and check latency, pulse width, results and array
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] idx, input logic [18:0] hi,
                                 input logic [25:0] lo0, input logic [25:0] lo1, input bit inject);
        logic [3:0] widx;
        int         lat;
        int         lat_exp;
        bit         found;
        checkOutput("ready_before", op_ready, 1'b1);
        op_valid    = 1'b1;
        op          = o;
        index_in    = idx;
        entryhi_in  = hi;
        entrylo0_in = lo0;
        entrylo1_in = lo1;
        widx        = (o == 2'd2) ? 4'(m_rand) : idx;
        tick();
        op_valid    = 1'b0;
        index_in    = 4'($urandom);
        entryhi_in  = 19'($urandom);
        entrylo0_in = 26'($urandom);
        entrylo1_in = 26'($urandom);
        lat_exp = 1;
        case (o)
            2'd0: m_rd = m_mem[idx];
            2'd1, 2'd2: m_mem[widx] = {hi, lo1, lo0};
            default: begin
                found = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (!found && m_mem[k][70:52] == hi) begin
                        found         = 1'b1;
                        m_probe_index = 4'(k);
                        lat_exp       = k + 2;
                    end
                end
                m_probe_miss = !found;
                if (!found) lat_exp = 17;
            end
        endcase
        lat = 1;
        while (op_done !== 1'b1 && lat < 40) begin
            checkOutput("ready_busy", op_ready, 1'b0);
            if (inject) begin
                op_valid    = 1'b1;
                op          = 2'd1;
                index_in    = 4'($urandom);
                entryhi_in  = 19'($urandom);
                entrylo0_in = 26'($urandom);
                entrylo1_in = 26'($urandom);
            end
            tick();
            lat++;
        end
        checkOutput("ready_in_done", op_ready, 1'b0);
        op_valid = 1'b0;
        checkOutput("latency", lat, lat_exp);
        tick();
        checkOutput("done_pulse_end", op_done, 1'b0);
        checkOutput("ready_after", op_ready, 1'b1);
        checkResults("op");
        checkEntries("op");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op = '0; index_in = '0; entryhi_in = '0;
        entrylo0_in = '0; entrylo1_in = '0; wired_in = '0; wired_we = 1'b0;
        resetModel();
        tick();
        tick();
        rst_n = 1'b1;
        $display("[TB] reset state");
        checkOutput("rst_random", random_out, 4'd15);
        checkOutput("rst_ready", op_ready, 1'b1);
        checkOutput("rst_done", op_done, 1'b0);
        checkResults("rst");
        checkEntries("rst");

        $display("[TB] TLBWI then TLBR index 5");
        applyStimulus(2'd1, 4'd5, 19'h12345, {24'h000ABC, 1'b1, 1'b1}, {24'h000DEF, 1'b0, 1'b1}, 1'b0);
        applyStimulus(2'd0, 4'd5, 19'h0, 26'h0, 26'h0, 1'b0);
        checkOutput("tlbr_hi",  rd_entryhi,  19'h12345);
        checkOutput("tlbr_lo0", rd_entrylo0, {24'h000ABC, 2'b11});
        checkOutput("tlbr_lo1", rd_entrylo1, {24'h000DEF, 2'b01});

        $display("[TB] TLBP with two matches");
        applyStimulus(2'd1, 4'd2, 19'h00040, {24'h000111, 2'b00}, {24'h000222, 2'b00}, 1'b0);
        applyStimulus(2'd1, 4'd9, 19'h00040, {24'h000333, 2'b11}, {24'h000444, 2'b11}, 1'b0);
        applyStimulus(2'd3, 4'd0, 19'h00040, 26'h0, 26'h0, 1'b0);
        checkOutput("probe_hit_idx",  probe_index, 4'd2);
        checkOutput("probe_hit_miss", probe_miss, 1'b0);

        $display("[TB] TLBP miss with requests during scan");
        applyStimulus(2'd3, 4'd0, 19'h7FFFF, 26'h0, 26'h0, 1'b1);
        checkOutput("probe_miss_flag", probe_miss, 1'b1);
        checkOutput("probe_miss_idx", probe_index, 4'd2);

        $display("[TB] Wired = 12 sequence and TLBWR");
        wired_in = 4'd12;
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("wired12_seq%0d", i), random_out, seq[i]);
            tick();
        end
        applyStimulus(2'd2, 4'd0, 19'h0ABCD, {24'h00F00D, 2'b11}, {24'h00BEEF, 2'b10}, 1'b0);
        wired_in = 4'd15;
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("wired15_hold", random_out, 4'd15);
            tick();
        end

        $display("[TB] reset during TLBP scan");
        op_valid = 1'b1; op = 2'd3; entryhi_in = 19'h7FFFF;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        resetModel();
        for (int i = 0; i < 4; i++) begin
            checkOutput("scanrst_done", op_done, 1'b0);
            checkOutput("scanrst_ready", op_ready, 1'b1);
            tick();
        end
        checkResults("scanrst");
        checkEntries("scanrst");

        $display("[TB] reset in TLBWI accept cycle");
        rst_n = 1'b0; op_valid = 1'b1; op = 2'd1; index_in = 4'd3;
        entryhi_in = 19'h55555; entrylo0_in = 26'h3FFFFFF; entrylo1_in = 26'h2AAAAAA;
        tick();
        rst_n = 1'b1;
        op_valid = 1'b0;
        checkOutput("wirst_done", op_done, 1'b0);
        checkOutput("wirst_ready", op_ready, 1'b1);
        checkOutput("wirst_entry3", tlb_entries[3], 71'h0);
        tick();
        checkOutput("wirst_done2", op_done, 1'b0);
        checkEntries("wirst");

        $display("[TB] randomized operations");
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                wired_in = 4'($urandom_range(0, 15));
                wired_we = 1'b1;
                tick();
                wired_we = 1'b0;
            end
            r_op  = 2'($urandom_range(0, 3));
            r_idx = 4'($urandom);
            r_hi  = 19'($urandom_range(0, 7)) << 4;
            if ($urandom_range(0, 7) == 0) r_hi = 19'h7FFF0;
            r_lo0 = 26'($urandom);
            r_lo1 = 26'($urandom);
            applyStimulus(r_op, r_idx, r_hi, r_lo0, r_lo1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
